// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes chip reset release, holds all domains in reset,
// then releases them one at a time in index order; software request re-runs it.
module rst_sequencer #(
  parameter int NUM_DOM     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 8,
  parameter int STEP_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               rst_done,
  output logic               sw_rst_ack
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_REL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_n;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOM-1:0]     dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;

  // Assert asynchronously, release only after the chain fills with ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    if (sync_rst_n) begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int k = 0; k < NUM_DOM; k++)
              if (IDX_W'(k) == idx_q) dom_d[k] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Requests only count here; during sequencing they are dropped.
          if (sw_rst_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            done_d  = 1'b0;
            ack_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign dom_rst_n  = dom_q;
  assign rst_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default instance plus a minimum-parameter instance,
// checked every cycle against a release-time model and at hand-computed edges.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       sw_min = 1'b0;
  logic [3:0] dom;
  logic       done, ack;
  logic [0:0] dom_m;
  logic       done_m, ack_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rst_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .dom_rst_n(dom), .rst_done(done), .sw_rst_ack(ack)
  );

  rst_sequencer #(.NUM_DOM(1), .SYNC_STAGES(2), .HOLD_CYC(1), .STEP_CYC(1), .CNT_W(8)) u_min (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_min),
    .dom_rst_n(dom_m), .rst_done(done_m), .sw_rst_ack(ack_m)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts edges since E0 of the current sequence (-1 = not started).
  // Domain k is released once t reaches HOLD + (k+1)*STEP - 1.
  function automatic logic [3:0] exp_dom(input int t, input int h, input int s, input int n);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = (t >= h + (k + 1) * s - 1);
    return r;
  endfunction

  localparam int TD_A = 8 + 4 * 4 - 1;
  localparam int TD_B = 1 + 1 * 1 - 1;

  int a_sync, a_t, b_sync, b_t;
  logic a_ack, b_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= 0; a_t <= -1; a_ack <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      if (a_sync < 2) a_sync <= a_sync + 1;
      else if (a_t >= TD_A && sw_rst_req) begin a_t <= -1; a_ack <= 1'b1; end
      else if (a_t < TD_A) a_t <= a_t + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_sync <= 0; b_t <= -1; b_ack <= 1'b0;
    end else begin
      b_ack <= 1'b0;
      if (b_sync < 2) b_sync <= b_sync + 1;
      else if (b_t >= TD_B && sw_min) begin b_t <= -1; b_ack <= 1'b1; end
      else if (b_t < TD_B) b_t <= b_t + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_dom", 32'(dom), 32'(exp_dom(a_t, 8, 4, 4)));
    chk("model_done", 32'(done), 32'(a_t >= TD_A));
    chk("model_ack", 32'(ack), 32'(a_ack));
    chk("model_min_dom", 32'(dom_m), 32'(exp_dom(b_t, 1, 1, 1)));
    chk("model_min_done", 32'(done_m), 32'(b_t >= TD_B));
    chk("model_min_ack", 32'(ack_m), 32'(b_ack));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic por();
    rst_n = 1'b0;
    #20;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    // 1: power-on
    #100;
    chk("por_dom", 32'(dom), 32'h0);
    chk("por_done", 32'(done), 32'h0);
    chk("por_ack", 32'(ack), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(3);
    chk("min_e3_dom", 32'(dom_m), 32'h0);
    step(1);
    chk("min_e4_dom", 32'(dom_m), 32'h1);
    chk("min_e4_done", 32'(done_m), 32'h1);
    step(9);
    chk("s1_e13", 32'(dom), 32'h0);
    step(1);
    chk("s1_e14", 32'(dom), 32'h1);
    step(4);
    chk("s1_e18", 32'(dom), 32'h3);
    step(4);
    chk("s1_e22", 32'(dom), 32'h7);
    step(3);
    chk("s1_e25_done", 32'(done), 32'h0);
    step(1);
    chk("s1_e26", 32'(dom), 32'hf);
    chk("s1_e26_done", 32'(done), 32'h1);

    // 2: software reset from DONE, sampled at edge S
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("s2_ack", 32'(ack), 32'h1);
    chk("s2_dom", 32'(dom), 32'h0);
    chk("s2_done", 32'(done), 32'h0);
    step(1);
    chk("s2_ack_off", 32'(ack), 32'h0);
    step(10);
    chk("s2_s11", 32'(dom), 32'h0);
    step(1);
    chk("s2_s12", 32'(dom), 32'h1);
    step(12);
    chk("s2_s24", 32'(dom), 32'hf);
    chk("s2_s24_done", 32'(done), 32'h1);

    // 3: request during RELEASE is ignored; held high it retriggers from DONE
    por();
    step(15);
    sw_rst_req = 1'b1;
    step(4);
    chk("s3_e19", 32'(dom), 32'h3);
    chk("s3_no_ack", 32'(ack), 32'h0);
    step(3);
    chk("s3_e22", 32'(dom), 32'h7);
    step(4);
    chk("s3_e26", 32'(dom), 32'hf);
    chk("s3_e26_done", 32'(done), 32'h1);
    step(1);
    chk("s3_e27_ack", 32'(ack), 32'h1);
    chk("s3_e27_dom", 32'(dom), 32'h0);
    chk("s3_e27_done", 32'(done), 32'h0);
    sw_rst_req = 1'b0;
    step(24);
    chk("s3_e51", 32'(dom), 32'hf);

    // 4: async reset mid-RELEASE
    por();
    step(18);
    chk("s4_e18", 32'(dom), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_async_dom", 32'(dom), 32'h0);
    chk("s4_async_done", 32'(done), 32'h0);
    #20;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(13);
    chk("s4_e13", 32'(dom), 32'h0);
    step(1);
    chk("s4_e14", 32'(dom), 32'h1);
    step(12);
    chk("s4_e26", 32'(dom), 32'hf);
    chk("s4_e26_done", 32'(done), 32'h1);

    // 5: 2 ns glitch while in DONE
    #2 rst_n = 1'b0;
    #1;
    chk("s5_glitch_dom", 32'(dom), 32'h0);
    chk("s5_glitch_done", 32'(done), 32'h0);
    chk("s5_glitch_min", 32'(dom_m), 32'h0);
    #1 rst_n = 1'b1;
    step(14);
    chk("s5_e14", 32'(dom), 32'h1);
    step(12);
    chk("s5_e26", 32'(dom), 32'hf);
    chk("s5_e26_done", 32'(done), 32'h1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
